// File: rtl/syn_tx.sv
// syn_tx -- once-per-second time-sync frame transmitter for a 485 link.
//
// Keeps a local seconds counter (utc_sec) advanced by a microsecond tick.
// Each second rollover, if enabled and idle, it sends one frame: a lead of
// two idle-high bits, the bytes A5, utc[31:24], utc[23:16], utc[15:8] and
// utc[7:0] as 8N1, and one idle-high tail bit.
//
// Build option: define SYN_TX_CHK_EN to append an XOR checksum byte.
// The frame is then 6 bytes and 63 bit times long instead of 5 bytes and
// 53 bit times.
//
// Ports:
//   clk_sys   in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   pluse_us  in   one-cycle tick once per microsecond
//   syn_en    in   level; allows new frames to start
//   utc_load  in   one-cycle strobe; loads utc_init and clears the us count
//   utc_init  in   [31:0] seconds value for utc_load
//   utc_sec   out  [31:0] current local seconds count
//   tx_syn    out  serial data; idles high
//   te_syn    out  driver enable; high only while a frame is driven
//   busy      out  high from frame start through the tail bit
//   err_ovf   out  one-cycle pulse when a second tick is dropped while busy
//
// state | meaning
// IDLE  | line released, waiting for a second tick
// LEAD  | two idle-high bits before the first byte
// BYTE  | shifting 8N1 bytes of the latched frame
// TAIL  | one idle-high bit, then release the driver

module syn_tx #(
  parameter int unsigned BAUD_DIV   = 100,
  parameter int unsigned US_PER_SEC = 1000000
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        pluse_us,
  input  logic        syn_en,
  input  logic        utc_load,
  input  logic [31:0] utc_init,
  output logic [31:0] utc_sec,
  output logic        tx_syn,
  output logic        te_syn,
  output logic        busy,
  output logic        err_ovf
);

  localparam int US_W = (US_PER_SEC > 1) ? $clog2(US_PER_SEC) : 1;

`ifdef SYN_TX_CHK_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif
  localparam int FW = NB * 8;

  localparam logic [15:0] BAUD_LD = 16'(BAUD_DIV - 1);
  localparam logic [US_W-1:0] US_LAST = US_W'(US_PER_SEC - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LEAD = 2'd1;
  localparam logic [1:0] ST_BYTE = 2'd2;
  localparam logic [1:0] ST_TAIL = 2'd3;

  logic [US_W-1:0] us_cnt;
  logic            us_wrap;
  logic            sec_tick;
  logic [31:0]     utc_nxt;
  logic [FW-1:0]   frame_load;

  logic [1:0]      state;
  logic [15:0]     baud_cnt;
  logic            bit_done;
  logic [3:0]      bit_cnt;
  logic [2:0]      byte_cnt;
  logic [9:0]      shreg;
  logic [FW-1:0]   frame_sr;

  assign us_wrap  = (us_cnt == US_LAST);
  // A load in the same cycle as the wrap wins, and suppresses the tick.
  assign sec_tick = pluse_us & us_wrap & ~utc_load;
  assign utc_nxt  = utc_sec + 32'd1;

`ifdef SYN_TX_CHK_EN
  logic [7:0] chk_byte;
  assign chk_byte   = 8'hA5 ^ utc_nxt[31:24] ^ utc_nxt[23:16] ^ utc_nxt[15:8] ^ utc_nxt[7:0];
  assign frame_load = {8'hA5, utc_nxt, chk_byte};
`else
  assign frame_load = {8'hA5, utc_nxt};
`endif

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      us_cnt  <= '0;
      utc_sec <= '0;
    end else if (utc_load) begin
      us_cnt  <= '0;
      utc_sec <= utc_init;
    end else if (pluse_us) begin
      if (us_wrap) begin
        us_cnt  <= '0;
        utc_sec <= utc_nxt;
      end else begin
        us_cnt <= us_cnt + 1'b1;
      end
    end
  end

  assign bit_done = (baud_cnt == 16'd0);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= BAUD_LD;
    end else if (state == ST_IDLE || bit_done) begin
      baud_cnt <= BAUD_LD;
    end else begin
      baud_cnt <= baud_cnt - 16'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '1;
      frame_sr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sec_tick && syn_en) begin
            state    <= ST_LEAD;
            frame_sr <= frame_load;
            bit_cnt  <= 4'd1;
          end
        end
        ST_LEAD: begin
          if (bit_done) begin
            if (bit_cnt == 4'd0) begin
              state    <= ST_BYTE;
              shreg    <= {1'b1, frame_sr[FW-1 -: 8], 1'b0};
              frame_sr <= {frame_sr[FW-9:0], 8'h00};
              bit_cnt  <= 4'd9;
              byte_cnt <= 3'(NB - 1);
            end else begin
              bit_cnt <= bit_cnt - 4'd1;
            end
          end
        end
        ST_BYTE: begin
          if (bit_done) begin
            if (bit_cnt == 4'd0) begin
              if (byte_cnt == 3'd0) begin
                state <= ST_TAIL;
                shreg <= '1;
              end else begin
                shreg    <= {1'b1, frame_sr[FW-1 -: 8], 1'b0};
                frame_sr <= {frame_sr[FW-9:0], 8'h00};
                bit_cnt  <= 4'd9;
                byte_cnt <= byte_cnt - 3'd1;
              end
            end else begin
              shreg   <= {1'b1, shreg[9:1]};
              bit_cnt <= bit_cnt - 4'd1;
            end
          end
        end
        ST_TAIL: begin
          if (bit_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
    end else begin
      err_ovf <= sec_tick & busy;
    end
  end

  // Outputs decode straight from the state register so reset releases the
  // line the instant rst_n falls.
  assign busy   = (state != ST_IDLE);
  assign te_syn = busy;
  assign tx_syn = (state == ST_BYTE) ? shreg[0] : 1'b1;

endmodule

// File: tb/tb_syn_tx.sv
// tb_syn_tx -- scoreboard bench for syn_tx with BAUD_DIV=4, US_PER_SEC=10.
// A reference model predicts second ticks and frames and pushes expected
// frames; a line monitor decodes tx_syn while te_syn is high and pops them.

module tb_syn_tx;

  localparam int BD = 4;
  localparam int US = 10;
`ifdef SYN_TX_CHK_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif
  localparam int NBITS = NB * 10 + 3;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        pluse_us;
  logic        syn_en;
  logic        utc_load;
  logic [31:0] utc_init;
  logic [31:0] utc_sec;
  logic        tx_syn;
  logic        te_syn;
  logic        busy;
  logic        err_ovf;

  syn_tx #(.BAUD_DIV(BD), .US_PER_SEC(US)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .pluse_us(pluse_us),
    .syn_en  (syn_en),
    .utc_load(utc_load),
    .utc_init(utc_init),
    .utc_sec (utc_sec),
    .tx_syn  (tx_syn),
    .te_syn  (te_syn),
    .busy    (busy),
    .err_ovf (err_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] make_frame(input logic [31:0] u);
    logic [63:0] f;
    f = {24'd0, 8'hA5, u};
`ifdef SYN_TX_CHK_EN
    f = {f[55:0], 8'hA5 ^ u[31:24] ^ u[23:16] ^ u[15:8] ^ u[7:0]};
`endif
    return f;
  endfunction

  // reference model
  logic [63:0] exp_q[$];
  int          m_us   = 0;
  logic [31:0] m_utc  = 0;
  int          m_busy = 0;
  int          m_err  = 0;

  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      m_us   = 0;
      m_utc  = 0;
      m_busy = 0;
      exp_q.delete();
    end else begin
      automatic bit busy_now = (m_busy > 0);
      if (m_busy > 0) m_busy--;
      if (utc_load) begin
        m_utc = utc_init;
        m_us  = 0;
      end else if (pluse_us) begin
        if (m_us == US - 1) begin
          m_us  = 0;
          m_utc = m_utc + 32'd1;
          if (busy_now) m_err++;
          else if (syn_en) begin
            exp_q.push_back(make_frame(m_utc));
            m_busy = NBITS * BD;
          end
        end else begin
          m_us++;
        end
      end
    end
  end

  // line monitor
  logic cap [0:299];
  int   te_len     = 0;
  bit   in_frame   = 0;
  int   frames     = 0;
  int   te_hi      = 0;
  int   err_seen   = 0;
  int   busy_te_bad = 0;

  always @(negedge clk_sys) begin
    if (!rst_n) begin
      te_len   = 0;
      in_frame = 0;
    end else begin
      if (err_ovf) err_seen++;
      if (busy !== te_syn) busy_te_bad++;
      if (te_syn) begin
        if (te_len < 300) cap[te_len] = tx_syn;
        te_len++;
        te_hi++;
        in_frame = 1;
      end else if (in_frame) begin
        automatic logic [63:0] act = 0;
        automatic logic [7:0]  b;
        automatic bit          ok = (te_len == NBITS * BD);
        automatic int          base;
        frames++;
        chk("te_len", 64'(te_len), 64'(NBITS * BD));
        if (ok) begin
          ok = ok && cap[BD/2] && cap[BD + BD/2];
          for (int k = 0; k < NB; k++) begin
            base = 2 + 10 * k;
            ok = ok && !cap[base * BD + BD/2] && cap[(base + 9) * BD + BD/2];
            for (int i = 0; i < 8; i++) b[i] = cap[(base + 1 + i) * BD + BD/2];
            act = (act << 8) | 64'(b);
          end
          ok = ok && cap[(NBITS - 1) * BD + BD/2];
        end
        chk("framing", 64'(ok), 64'd1);
        if (exp_q.size() == 0) chk("frame_unexpected", act, 64'hDEAD);
        else chk("frame", act, exp_q.pop_front());
        te_len   = 0;
        in_frame = 0;
      end
    end
  end

  task automatic send_us(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys) pluse_us = 1'b1;
      @(negedge clk_sys) pluse_us = 1'b0;
      repeat (gap - 1) @(negedge clk_sys);
    end
  endtask

  task automatic load(input logic [31:0] v);
    @(negedge clk_sys);
    utc_load = 1'b1;
    utc_init = v;
    @(negedge clk_sys);
    utc_load = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !te_syn && !in_frame) break;
      @(negedge clk_sys);
    end
    repeat (2) @(negedge clk_sys);
    chk("drain_timeout", 64'(i < 3000), 64'd1);
  endtask

  initial begin
    int f0, e0, h0;
    rst_n = 1'b0; pluse_us = 1'b0; syn_en = 1'b0; utc_load = 1'b0; utc_init = '0;
    repeat (2) @(negedge clk_sys);
    chk("rst_utc", 64'(utc_sec), 64'd0);
    chk("rst_tx", 64'(tx_syn), 64'd1);
    chk("rst_te", 64'(te_syn), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_ovf), 64'd0);
    rst_n = 1'b1;

    // basic frame
    syn_en = 1'b1;
    load(32'h10);
    send_us(10, 30);
    chk("utc_basic", 64'(utc_sec), 64'h11);
    wait_idle();

    // 32-bit wrap
    load(32'hFFFF_FFFF);
    send_us(10, 30);
    chk("utc_wrap", 64'(utc_sec), 64'h0);
    wait_idle();

    // overflow: second tick lands mid-frame
    f0 = frames; e0 = err_seen;
    load(32'h300);
    send_us(20, 10);
    wait_idle();
    chk("ovf_err_pulse", 64'(err_seen - e0), 64'd1);
    chk("ovf_frames", 64'(frames - f0), 64'd1);

    // load coincident with the wrapping pulse
    load(32'h0);
    send_us(9, 5);
    f0 = frames; h0 = te_hi;
    @(negedge clk_sys);
    pluse_us = 1'b1; utc_load = 1'b1; utc_init = 32'h1234;
    @(negedge clk_sys);
    pluse_us = 1'b0; utc_load = 1'b0;
    chk("ld_wrap_utc", 64'(utc_sec), 64'h1234);
    repeat (40) @(negedge clk_sys);
    chk("ld_wrap_noframe", 64'(te_hi - h0), 64'd0);
    send_us(9, 5);
    chk("ld_wrap_uscnt", 64'(utc_sec), 64'h1234);
    send_us(1, 5);
    chk("ld_wrap_next", 64'(utc_sec), 64'h1235);
    wait_idle();
    chk("ld_wrap_frames", 64'(frames - f0), 64'd1);

    // async reset during the third byte
    load(32'h100);
    send_us(10, 30);
    for (int i = 0; i < 300 && te_len < 100; i++) @(negedge clk_sys);
    chk("rst_mid_reached", 64'(te_len >= 100), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", 64'(tx_syn), 64'd1);
    chk("rst_mid_te", 64'(te_syn), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_utc", 64'(utc_sec), 64'd0);
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    h0 = te_hi;
    send_us(9, 30);
    chk("rst_rel_noframe", 64'(te_hi - h0), 64'd0);
    send_us(1, 30);
    chk("rst_rel_utc", 64'(utc_sec), 64'd1);
    wait_idle();

    // syn_en low at the tick
    syn_en = 1'b0;
    load(32'h500);
    h0 = te_hi;
    send_us(10, 30);
    repeat (20) @(negedge clk_sys);
    chk("dis_utc", 64'(utc_sec), 64'h501);
    chk("dis_noframe", 64'(te_hi - h0), 64'd0);

    // syn_en cleared mid-frame
    syn_en = 1'b1;
    f0 = frames;
    load(32'h200);
    send_us(10, 30);
    syn_en = 1'b0;
    wait_idle();
    chk("dis_mid_frames", 64'(frames - f0), 64'd1);

    chk("err_vs_model", 64'(err_seen), 64'(m_err));
    chk("busy_te", 64'(busy_te_bad), 64'd0);
    chk("utc_vs_model", 64'(utc_sec), 64'(m_utc));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
